mips_mc_ctrl: RTL and testbench

//  Multicycle control FSM placed directly upstream of the register file. Latches each

---
 rtl/mips_pkg.sv | 59 +++++
 rtl/mips_decode.sv | 54 +++++
 rtl/mips_mc_ctrl.sv | 166 ++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, funct codes,
// ALU/PC-source codes, FSM state encoding and the decoder payload.
package mips_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 5;
    localparam int unsigned AOPW = 3;
    localparam int unsigned PCSW = 2;
    localparam int unsigned STW  = 3;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [AOPW-1:0] ALU_ADD = 3'd0;
    localparam logic [AOPW-1:0] ALU_SUB = 3'd1;
    localparam logic [AOPW-1:0] ALU_AND = 3'd2;
    localparam logic [AOPW-1:0] ALU_OR  = 3'd3;
    localparam logic [AOPW-1:0] ALU_SLT = 3'd4;

    localparam logic [PCSW-1:0] PC_SEQ = 2'd0;
    localparam logic [PCSW-1:0] PC_BR  = 2'd1;
    localparam logic [PCSW-1:0] PC_JMP = 2'd2;

    typedef enum logic [STW-1:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    typedef struct packed {
        logic [AOPW-1:0] alu_op;
        logic            alu_src_b;
        logic            wb_sel;
        logic [RW-1:0]   dr;
        logic            is_lw;
        logic            is_sw;
        logic            is_beq;
        logic            is_j;
        logic            is_wb;
        logic            illegal;
    } dec_t;

    function automatic logic [XLEN-1:0] sign_ext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/mips_decode.sv
// Combinational instruction decoder: opcode/funct/register fields to control payload.
module mips_decode
    import mips_pkg::*;
(
    input  logic [5:0]    op_i,
    input  logic [5:0]    funct_i,
    input  logic [RW-1:0] rt_i,
    input  logic [RW-1:0] rd_i,
    output dec_t          dec_o
);

    always_comb begin
        dec_o        = '0;
        dec_o.alu_op = ALU_ADD;
        dec_o.dr     = rt_i;
        case (op_i)
            OP_RTYPE: begin
                dec_o.dr    = rd_i;
                dec_o.is_wb = 1'b1;
                case (funct_i)
                    FN_ADD:  dec_o.alu_op = ALU_ADD;
                    FN_SUB:  dec_o.alu_op = ALU_SUB;
                    FN_AND:  dec_o.alu_op = ALU_AND;
                    FN_OR:   dec_o.alu_op = ALU_OR;
                    FN_SLT:  dec_o.alu_op = ALU_SLT;
                    default: begin
                        dec_o.illegal = 1'b1;
                        dec_o.is_wb   = 1'b0;
                    end
                endcase
            end
            OP_ADDI: begin
                dec_o.alu_src_b = 1'b1;
                dec_o.is_wb     = 1'b1;
            end
            OP_LW: begin
                dec_o.alu_src_b = 1'b1;
                dec_o.wb_sel    = 1'b1;
                dec_o.is_lw     = 1'b1;
            end
            OP_SW: begin
                dec_o.alu_src_b = 1'b1;
                dec_o.is_sw     = 1'b1;
            end
            OP_BEQ: begin
                dec_o.alu_op = ALU_SUB;
                dec_o.is_beq = 1'b1;
            end
            OP_J:    dec_o.is_j    = 1'b1;
            default: dec_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) feeding the register file.
// Optional single-step gating of FETCH when STEP_EN is defined.
module mips_mc_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 1
)
(
    input  logic              CLK,
    input  logic              RSTn,
    input  logic [XLEN-1:0]   Instr,
    input  logic              instr_valid,
    output logic              instr_ready,
`ifdef STEP_EN
    input  logic              step,
`endif
    input  logic              Zero,
    output logic [RW-1:0]     SR1,
    output logic [RW-1:0]     SR2,
    output logic [RW-1:0]     DR,
    output logic              RegW,
    output logic [XLEN-1:0]   Imm,
    output logic [AOPW-1:0]   ALUOp,
    output logic              ALUSrcB,
    output logic              WBSel,
    output logic              MemR,
    output logic              MemW,
    output logic              PCWrite,
    output logic [PCSW-1:0]   PCSrc,
    output logic              illegal,
    output logic [STW-1:0]    state_o
);

    localparam int unsigned CNT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   ir_q, ir_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              step_ok;
    dec_t              dec;

    mips_decode u_dec (
        .op_i    (ir_q[31:26]),
        .funct_i (ir_q[5:0]),
        .rt_i    (ir_q[20:16]),
        .rd_i    (ir_q[15:11]),
        .dec_o   (dec)
    );

`ifdef STEP_EN
    logic step_q, pend_q, pend_d;

    // A rising edge of step is latched until a fetch consumes it.
    always_comb begin
        step_ok = pend_q | (step & ~step_q);
        pend_d  = step_ok;
        if (state_q == S_FETCH && instr_valid && step_ok) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            step_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            step_q <= step;
            pend_q <= pend_d;
        end
    end
`else
    assign step_ok = 1'b1;
`endif

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
        end
    end

    // Fields come straight from the latched IR so they stay stable until the next fetch.
    assign SR1     = ir_q[25:21];
    assign SR2     = ir_q[20:16];
    assign DR      = dec.dr;
    assign Imm     = sign_ext16(ir_q[15:0]);
    assign ALUOp   = dec.alu_op;
    assign ALUSrcB = dec.alu_src_b;
    assign WBSel   = dec.wb_sel;
    assign state_o = state_q;

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        cnt_d       = '0;
        instr_ready = 1'b0;
        RegW        = 1'b0;
        MemR        = 1'b0;
        MemW        = 1'b0;
        PCWrite     = 1'b0;
        PCSrc       = PC_SEQ;
        illegal     = 1'b0;
        case (state_q)
            S_FETCH: begin
                instr_ready = step_ok;
                if (instr_valid && step_ok) begin
                    ir_d    = Instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec.illegal) begin
                    illegal = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (dec.is_beq) begin
                    PCWrite = 1'b1;
                    PCSrc   = Zero ? PC_BR : PC_SEQ;
                    state_d = S_FETCH;
                end else if (dec.is_j) begin
                    PCWrite = 1'b1;
                    PCSrc   = PC_JMP;
                    state_d = S_FETCH;
                end else if (dec.is_lw || dec.is_sw) begin
                    state_d = S_MEM;
                end else if (dec.is_wb) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                MemR = dec.is_lw;
                MemW = dec.is_sw;
                if (cnt_q == CNT_W'(MEM_WAIT - 1)) begin
                    if (dec.is_sw) begin
                        PCWrite = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WB: begin
                // r0 is hard-wired and r1 is overwritten by the switches every cycle.
                RegW    = (dec.dr > RW'(1));
                PCWrite = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: table of instructions with per-instruction
// expected traces, plus hand-written reset and idle sequences.
module tb_mips_mc_ctrl;
    import mips_pkg::*;

    localparam int unsigned MW   = 3;
    localparam int          NVEC = 15;

    logic            CLK = 1'b0;
    logic            RSTn;
    logic [31:0]     Instr;
    logic            instr_valid;
    logic            instr_ready;
    logic            Zero;
    logic [4:0]      SR1, SR2, DR;
    logic            RegW;
    logic [31:0]     Imm;
    logic [2:0]      ALUOp;
    logic            ALUSrcB, WBSel, MemR, MemW, PCWrite;
    logic [1:0]      PCSrc;
    logic            illegal;
    logic [2:0]      state_o;

    mips_mc_ctrl #(.MEM_WAIT(MW)) dut (
        .CLK(CLK), .RSTn(RSTn), .Instr(Instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .Zero(Zero), .SR1(SR1), .SR2(SR2), .DR(DR),
        .RegW(RegW), .Imm(Imm), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB), .WBSel(WBSel),
        .MemR(MemR), .MemW(MemW), .PCWrite(PCWrite), .PCSrc(PCSrc),
        .illegal(illegal), .state_o(state_o)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] instr;
        logic        zero;
        int          lat;
        logic [4:0]  sr1;
        logic [4:0]  sr2;
        logic [31:0] imm;
        logic [2:0]  aluop;
        logic        srcb;
        int          regw;
        logic [4:0]  dr;
        logic        wbsel;
        int          memr;
        int          memw;
        int          pcw;
        logic [1:0]  pcsrc;
        int          ill;
    } vec_t;

    vec_t vecs [NVEC];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Issues one instruction from FETCH and records what the FSM drives until it returns.
    task automatic run(input logic [31:0] ins, input logic z, output vec_t g, output bit done);
        int rdy_bad;
        g = '{default: 0};
        rdy_bad = 0;
        done = 1'b0;
        @(negedge CLK);
        Instr = ins; instr_valid = 1'b1; Zero = z;
        chk("ready in FETCH", {31'd0, instr_ready}, 32'd1);
        g.lat = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            instr_valid = 1'b0;
            if (state_o == 3'd0) begin
                done = 1'b1;
                break;
            end
            g.lat++;
            if (instr_ready) rdy_bad++;
            if (state_o == 3'd1) begin
                g.sr1 = SR1; g.sr2 = SR2; g.imm = Imm;
            end
            if (state_o == 3'd2) begin
                g.aluop = ALUOp; g.srcb = ALUSrcB;
            end
            if (RegW) begin
                g.regw++; g.dr = DR; g.wbsel = WBSel;
            end
            g.memr += int'(MemR);
            g.memw += int'(MemW);
            if (PCWrite) begin
                g.pcw++; g.pcsrc = PCSrc;
            end
            g.ill += int'(illegal);
        end
        chk("ready outside FETCH", 32'(rdy_bad), 32'd0);
    endtask

    initial begin
        vec_t g;
        bit   done;

        //          instr         z     lat      sr1    sr2    imm            alu   sb    rw dr     wbs   mr mw pw pcs    ill
        vecs[0]  = '{32'h00851820, 1'b0, 4,      5'd4,  5'd5,  32'h00001820, 3'd0, 1'b0, 1, 5'd3,  1'b0, 0, 0, 1, 2'd0, 0}; // add $3,$4,$5
        vecs[1]  = '{32'h8C220008, 1'b0, 4 + MW, 5'd1,  5'd2,  32'h00000008, 3'd0, 1'b1, 1, 5'd2,  1'b1, MW, 0, 1, 2'd0, 0}; // lw $2,8($1)
        vecs[2]  = '{32'h1000FFFF, 1'b1, 3,      5'd0,  5'd0,  32'hFFFFFFFF, 3'd1, 1'b0, 0, 5'd0,  1'b0, 0, 0, 1, 2'd1, 0}; // beq taken
        vecs[3]  = '{32'h1000FFFF, 1'b0, 3,      5'd0,  5'd0,  32'hFFFFFFFF, 3'd1, 1'b0, 0, 5'd0,  1'b0, 0, 0, 1, 2'd0, 0}; // beq not taken
        vecs[4]  = '{32'h20000005, 1'b0, 4,      5'd0,  5'd0,  32'h00000005, 3'd0, 1'b1, 0, 5'd0,  1'b0, 0, 0, 1, 2'd0, 0}; // addi $0
        vecs[5]  = '{32'h20010005, 1'b0, 4,      5'd0,  5'd1,  32'h00000005, 3'd0, 1'b1, 0, 5'd0,  1'b0, 0, 0, 1, 2'd0, 0}; // addi $1
        vecs[6]  = '{32'hFC000000, 1'b0, 2,      5'd0,  5'd0,  32'h00000000, 3'd0, 1'b0, 0, 5'd0,  1'b0, 0, 0, 1, 2'd0, 1}; // opcode 0x3F
        vecs[7]  = '{32'hACC50004, 1'b0, 3 + MW, 5'd6,  5'd5,  32'h00000004, 3'd0, 1'b1, 0, 5'd0,  1'b0, 0, MW, 1, 2'd0, 0}; // sw $5,4($6)
        vecs[8]  = '{32'h08000010, 1'b0, 3,      5'd0,  5'd0,  32'h00000010, 3'd0, 1'b0, 0, 5'd0,  1'b0, 0, 0, 1, 2'd2, 0}; // j
        vecs[9]  = '{32'h01093822, 1'b0, 4,      5'd8,  5'd9,  32'h00003822, 3'd1, 1'b0, 1, 5'd7,  1'b0, 0, 0, 1, 2'd0, 0}; // sub $7,$8,$9
        vecs[10] = '{32'h00851821, 1'b0, 2,      5'd4,  5'd5,  32'h00001821, 3'd0, 1'b0, 0, 5'd0,  1'b0, 0, 0, 1, 2'd0, 1}; // funct 0x21
        vecs[11] = '{32'h2062FFFE, 1'b0, 4,      5'd3,  5'd2,  32'hFFFFFFFE, 3'd0, 1'b1, 1, 5'd2,  1'b0, 0, 0, 1, 2'd0, 0}; // addi $2,$3,-2
        vecs[12] = '{32'h016C5025, 1'b0, 4,      5'd11, 5'd12, 32'h00005025, 3'd3, 1'b0, 1, 5'd10, 1'b0, 0, 0, 1, 2'd0, 0}; // or
        vecs[13] = '{32'h01CF682A, 1'b1, 4,      5'd14, 5'd15, 32'h0000682A, 3'd4, 1'b0, 1, 5'd13, 1'b0, 0, 0, 1, 2'd0, 0}; // slt
        vecs[14] = '{32'h00432024, 1'b0, 4,      5'd2,  5'd3,  32'h00002024, 3'd2, 1'b0, 1, 5'd4,  1'b0, 0, 0, 1, 2'd0, 0}; // and

        RSTn = 1'b0; Instr = '0; instr_valid = 1'b0; Zero = 1'b0;
        repeat (2) @(negedge CLK);
        chk("reset state", 32'(state_o), 32'd0);
        chk("reset ready", {31'd0, instr_ready}, 32'd1);
        chk("reset strobes", {26'd0, RegW, MemR, MemW, PCWrite, illegal, WBSel}, 32'd0);
        chk("reset fields", {SR1, SR2, DR, ALUOp, ALUSrcB, PCSrc, 11'd0}, 32'd0);
        chk("reset imm", Imm, 32'd0);
        RSTn = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            run(vecs[i].instr, vecs[i].zero, g, done);
            chk($sformatf("v%0d return to FETCH", i), {31'd0, done}, 32'd1);
            chk($sformatf("v%0d latency", i), 32'(g.lat), 32'(vecs[i].lat));
            chk($sformatf("v%0d SR1", i), 32'(g.sr1), 32'(vecs[i].sr1));
            chk($sformatf("v%0d SR2", i), 32'(g.sr2), 32'(vecs[i].sr2));
            chk($sformatf("v%0d Imm", i), g.imm, vecs[i].imm);
            chk($sformatf("v%0d ALUOp", i), 32'(g.aluop), 32'(vecs[i].aluop));
            chk($sformatf("v%0d ALUSrcB", i), 32'(g.srcb), 32'(vecs[i].srcb));
            chk($sformatf("v%0d RegW pulses", i), 32'(g.regw), 32'(vecs[i].regw));
            chk($sformatf("v%0d DR", i), 32'(g.dr), 32'(vecs[i].dr));
            chk($sformatf("v%0d WBSel", i), 32'(g.wbsel), 32'(vecs[i].wbsel));
            chk($sformatf("v%0d MemR cycles", i), 32'(g.memr), 32'(vecs[i].memr));
            chk($sformatf("v%0d MemW cycles", i), 32'(g.memw), 32'(vecs[i].memw));
            chk($sformatf("v%0d PCWrite pulses", i), 32'(g.pcw), 32'(vecs[i].pcw));
            chk($sformatf("v%0d PCSrc", i), 32'(g.pcsrc), 32'(vecs[i].pcsrc));
            chk($sformatf("v%0d illegal pulses", i), 32'(g.ill), 32'(vecs[i].ill));
        end

        // Reset taken in DECODE discards the instruction.
        @(negedge CLK);
        Instr = 32'h00851820; instr_valid = 1'b1;
        @(negedge CLK);
        instr_valid = 1'b0;
        chk("midrst in DECODE", 32'(state_o), 32'd1);
        chk("midrst SR1 before", 32'(SR1), 32'd4);
        RSTn = 1'b0;
        #1;
        chk("midrst state", 32'(state_o), 32'd0);
        chk("midrst strobes", {28'd0, RegW, PCWrite, MemW, MemR}, 32'd0);
        chk("midrst ready", {31'd0, instr_ready}, 32'd1);
        chk("midrst IR cleared", {22'd0, SR1, SR2}, 32'd0);
        @(negedge CLK);
        RSTn = 1'b1;
        // Idle FETCH with no valid instruction: no strobes, no state change.
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            chk($sformatf("idle%0d state", k), 32'(state_o), 32'd0);
            chk($sformatf("idle%0d strobes", k), {27'd0, RegW, PCWrite, MemW, MemR, illegal}, 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
